// File: rtl/spiral_scan_gen.sv
// spiral_scan_gen: raster scan producing centred coordinates for a polar converter, with syncs delayed to match its latency
module spiral_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LAT      = 5
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  output logic [6:0] o_xval,
  output logic [6:0] o_yval,
  output logic       o_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active_d,
  output logic       o_hsync_d,
  output logic       o_vsync_d,
  output logic       o_frame,
  output logic [7:0] o_frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_end, v_end, first, act, hs, vs;
  logic signed [10:0] xs, ys;
  logic [2:0] dly [LAT];
  // decode the pre-increment position into the pixel attributes about to be registered
  always_comb begin
    h_end = int'(h) == H_TOTAL - 1;
    v_end = int'(v) == V_TOTAL - 1;
    first = int'(h) == 0 && int'(v) == 0;
    act   = int'(h) < H_ACTIVE && int'(v) < V_ACTIVE;
    hs    = !(int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC);
    vs    = !(int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC);
    xs    = 11'(int'(h) - H_ACTIVE / 2);
    ys    = 11'(int'(v) - V_ACTIVE / 2);
  end
  // advance the raster, register outputs and shift the converter-latency delay line
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h           <= '0;
      v           <= '0;
      o_xval      <= '0;
      o_yval      <= '0;
      o_active    <= 1'b0;
      o_hsync     <= 1'b1;
      o_vsync     <= 1'b1;
      o_frame     <= 1'b0;
      o_frame_cnt <= '0;
      for (int i = 0; i < LAT; i++) dly[i] <= 3'b011;
      o_active_d  <= 1'b0;
      o_hsync_d   <= 1'b1;
      o_vsync_d   <= 1'b1;
    end else if (i_ce) begin
      h           <= h_end ? '0 : h + 1'b1;
      v           <= h_end ? (v_end ? '0 : v + 1'b1) : v;
      o_xval      <= 7'(xs >>> 3);
      o_yval      <= 7'(ys >>> 3);
      o_active    <= act;
      o_hsync     <= hs;
      o_vsync     <= vs;
      o_frame     <= first;
      o_frame_cnt <= o_frame_cnt + 8'(first);
      dly[0]      <= {act, hs, vs};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      {o_active_d, o_hsync_d, o_vsync_d} <= dly[LAT-1];
    end
  end
endmodule

// File: tb/tb_spiral_scan_gen.sv
// tb_spiral_scan_gen: random-enable scan checked against a pixel-index model, on default and shrunken timings
module tb_spiral_scan_gen;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_a = 1, ce_a = 0, rst_b = 1, ce_b = 0;
  logic done_a = 0, done_b = 0;
  int na = 0, nb = 0;
  int errors = 0, checks = 0, prints = 0;

  logic [6:0] a_x, a_y, b_x, b_y;
  logic a_act, a_hs, a_vs, a_ad, a_hd, a_vd, a_fr;
  logic b_act, b_hs, b_vs, b_ad, b_hd, b_vd, b_fr;
  logic [7:0] a_fc, b_fc;

  spiral_scan_gen dut (
    .i_clk(clk), .i_reset_n(rst_a), .i_ce(ce_a),
    .o_xval(a_x), .o_yval(a_y), .o_active(a_act), .o_hsync(a_hs), .o_vsync(a_vs),
    .o_active_d(a_ad), .o_hsync_d(a_hd), .o_vsync_d(a_vd),
    .o_frame(a_fr), .o_frame_cnt(a_fc)
  );

  spiral_scan_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .LAT(3)
  ) dus (
    .i_clk(clk), .i_reset_n(rst_b), .i_ce(ce_b),
    .o_xval(b_x), .o_yval(b_y), .o_active(b_act), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_active_d(b_ad), .o_hsync_d(b_hd), .o_vsync_d(b_vd),
    .o_frame(b_fr), .o_frame_cnt(b_fc)
  );

  // number of enabled edges since reset; edge n registers pixel index n-1
  always @(posedge clk or negedge rst_a) if (!rst_a) na <= 0; else if (ce_a) na <= na + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) nb <= 0; else if (ce_b) nb <= nb + 1;

  function automatic logic [2:0] attr(int p, int ha, int hf, int hs, int ht, int va, int vf, int vs, int vt);
    int h = p % ht;
    int v = (p / ht) % vt;
    return {h < ha && v < va, !(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs)};
  endfunction

  function automatic logic [28:0] model(int n, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, int lat);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int p, h, v, x, y;
    logic [2:0] cur, del;
    if (n == 0) return {14'd0, 3'b011, 3'b011, 1'b0, 8'd0};
    p = n - 1;
    h = p % ht;
    v = (p / ht) % vt;
    x = (h - ha / 2) >>> 3;
    y = (v - va / 2) >>> 3;
    cur = attr(p, ha, hf, hs, ht, va, vf, vs, vt);
    del = n > lat ? attr(n - lat - 1, ha, hf, hs, ht, va, vf, vs, vt) : 3'b011;
    return {7'(x), 7'(y), cur, del, p % (ht * vt) == 0, 8'((p / (ht * vt) + 1) % 256)};
  endfunction

  task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 30) begin
        prints++;
        $display("FAIL %s n=%0d/%0d: got x=%h y=%h a/hs/vs=%b d=%b fr=%b fc=%0d, expected x=%h y=%h a/hs/vs=%b d=%b fr=%b fc=%0d",
                 nm, na, nb, act[28:22], act[21:15], act[14:12], act[11:9], act[8], act[7:0],
                 exp[28:22], exp[21:15], exp[14:12], exp[11:9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  // every cycle, both instances against the model
  always @(negedge clk) begin
    chk("scan_a", {a_x, a_y, a_act, a_hs, a_vs, a_ad, a_hd, a_vd, a_fr, a_fc},
        model(na, 640, 16, 96, 48, 480, 10, 2, 33, 5));
    chk("scan_b", {b_x, b_y, b_act, b_hs, b_vs, b_ad, b_hd, b_vd, b_fr, b_fc},
        model(nb, 8, 2, 3, 3, 6, 1, 2, 1, 3));
  end

  // default timing: first pixel, delay latency, hsync window, random enable, async reset mid-frame
  initial begin
    rst_a = 0;
    repeat (3) tk();
    rst_a = 1;
    ce_a = 1;
    for (int k = 1; k <= 800; k++) begin
      tk();
      if (k == 1) begin
        lit("first_x", int'(a_x), 'h58);
        lit("first_y", int'(a_y), 'h62);
        lit("first_active", int'(a_act), 1);
        lit("first_frame", int'(a_fr), 1);
        lit("first_fcnt", int'(a_fc), 1);
        lit("first_active_d", int'(a_ad), 0);
      end
      if (k == 5) lit("active_d_e5", int'(a_ad), 0);
      if (k == 6) lit("active_d_e6", int'(a_ad), 1);
      if (k == 656) lit("hsync_e656", int'(a_hs), 1);
      if (k == 657) lit("hsync_e657", int'(a_hs), 0);
      if (k == 752) lit("hsync_e752", int'(a_hs), 0);
      if (k == 753) lit("hsync_e753", int'(a_hs), 1);
    end
    repeat (1500) begin
      ce_a = $urandom_range(0, 3) != 0;
      tk();
    end
    ce_a = 0;
    repeat (10) tk();
    ce_a = 1;
    while (na < 80300) tk();
    ce_a = 0;
    #2;
    rst_a = 0;
    #1;
    lit("rst_x", int'(a_x), 0);
    lit("rst_y", int'(a_y), 0);
    lit("rst_active", int'(a_act), 0);
    lit("rst_syncs", int'({a_hs, a_vs}), 3);
    lit("rst_frame", int'({a_fr, a_fc}), 0);
    lit("rst_delayed", int'({a_ad, a_hd, a_vd}), 3);
    tk();
    tk();
    rst_a = 1;
    ce_a = 1;
    tk();
    lit("rerun_x", int'(a_x), 'h58);
    lit("rerun_y", int'(a_y), 'h62);
    lit("rerun_frame", int'({a_fr, a_fc}), 'h101);
    repeat (30) tk();
    done_a = 1;
  end

  // shrunken timing (16x10): frame pulses, vsync lines and frame-count wrap
  initial begin
    bit held = 0;
    rst_b = 0;
    repeat (3) tk();
    rst_b = 1;
    while (nb < 40961) begin
      ce_b = $urandom_range(0, 3) != 0;
      if (nb == 1000 && !held) begin
        held = 1;
        ce_b = 0;
        repeat (10) tk();
      end
      tk();
      if (nb == 97) lit("b_vsync_v6", int'(b_vs), 1);
      if (nb == 113) lit("b_vsync_v7", int'(b_vs), 0);
      if (nb == 145) lit("b_vsync_v9", int'(b_vs), 1);
      if (nb == 161) lit("b_frame2", int'({b_fr, b_fc, b_x}), {1'b1, 8'd2, 7'h7f});
      if (nb == 40801) lit("b_wrap", int'({b_fr, b_fc}), 'h100);
      if (nb == 40961) lit("b_after_wrap", int'({b_fr, b_fc}), 'h101);
    end
    done_b = 1;
  end

  initial begin
    fork
      wait (done_a && done_b);
      #2_000_000;
    join_any
    if (!(done_a && done_b)) begin
      errors++;
      checks++;
      $display("FAIL timeout: done=%b%b expected 11", done_a, done_b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spiral_scan_gen.md
SPIRAL_SCAN_GEN -- requirements
Module: spiral_scan_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; LAT 5 downstream polar-converter latency in i_ce cycles.
REQ-002 i_clk  input  1  sole clock, all flops on rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_ce  input  1  pixel enable; state advances only on edges with i_ce=1.
REQ-005 o_xval  output  7  signed centred x coordinate, fed to polar converter i_xval.
REQ-006 o_yval  output  7  signed centred y coordinate, fed to polar converter i_yval.
REQ-007 o_active  output  1  current pixel visible, aligned with o_xval/o_yval.
REQ-008 o_hsync, o_vsync  output  1 each  active-low syncs, aligned with o_xval/o_yval.
REQ-009 o_active_d, o_hsync_d, o_vsync_d  output  1 each  o_active/o_hsync/o_vsync delayed LAT i_ce cycles, aligned with converter o_phase.
REQ-010 o_frame  output  1  one-ce-cycle pulse marking pixel (0,0) of a frame, aligned with o_xval.
REQ-011 o_frame_cnt  output  8  frames started since reset, for spiral animation.

Function
REQ-012 Internal counters h (0..H_TOTAL-1, H_TOTAL=800) and v (0..V_TOTAL-1, V_TOTAL=525), both reset to 0.
REQ-013 On each i_ce edge: h increments; at h=H_TOTAL-1, h wraps to 0 and v increments; at v=V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0.
REQ-014 With i_ce=0 every register (counters, outputs, delay line, frame count) holds value.
REQ-015 All outputs are registered; on an i_ce edge they are computed from pre-increment (h,v).
REQ-016 o_xval = (h - H_ACTIVE/2) arithmetic-shifted right 3, computed in 11-bit signed then truncated to 7 bits; range -40..59, no overflow.
REQ-017 o_yval = (v - V_ACTIVE/2) arithmetic-shifted right 3, same width rule; range -30..35.
REQ-018 o_active = (h < H_ACTIVE) and (v < V_ACTIVE).
REQ-019 o_hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-020 o_vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-021 o_frame = 1 iff h=0 and v=0; o_frame_cnt increments on that same edge, wrapping 255->0.
REQ-022 Delay line: LAT-deep shift register of {active,hsync,vsync}, shifting only on i_ce edges, input taken from the values being registered into o_active/o_hsync/o_vsync; first stage loads in parallel with them, so the _d outputs equal the undelayed outputs from exactly LAT i_ce edges earlier.
REQ-023 The first frame after reset counts: the edge registering (0,0) sets o_frame=1 and o_frame_cnt=1.

Reset
REQ-024 i_reset_n=0 clears immediately, without a clock: h=0, v=0, o_xval=0, o_yval=0, o_active=0, o_hsync=1, o_vsync=1, o_frame=0, o_frame_cnt=0, all delay stages and _d outputs inactive (active 0, syncs 1).
REQ-025 Reset asserted mid-line or mid-frame fully restarts scan; first i_ce edge after release registers pixel (0,0).
REQ-026 Reset release is synchronised to no particular edge; state advances only on i_ce edges once i_reset_n=1.

Verification
REQ-027 Reset then first i_ce edge -> o_xval=-40 (7'h58), o_yval=-30 (7'h62), o_active=1, o_frame=1, o_frame_cnt=1, o_active_d=0.
REQ-028 Continuous i_ce from reset -> o_active_d first rises on i_ce edge 6 (5 edges after o_active); o_hsync low for exactly 96 edges starting on edge 657.
REQ-029 i_ce held low 10 clocks mid-line -> all outputs frozen; scan resumes at the next pixel with no skip or repeat.
REQ-030 Run 420000 i_ce edges -> edge 420001 shows o_frame=1, o_frame_cnt=2, o_xval=-40; o_vsync low on lines 490-491 only; run 256 frames -> o_frame_cnt wraps 255->0.
REQ-031 Assert i_reset_n=0 between clock edges at h=300,v=100 -> outputs take reset values before the next edge; after release behaviour matches REQ-027.
REQ-032 Connect to polar converter -> for pixel (h=640+,v) blanking, converter o_phase is ignored because o_active_d=0 on the same edge o_phase updates.
